// File: rtl/vfu_mem_pkg.sv
// Shared types and address helpers for the vector-core memory responder.
package vfu_mem_pkg;

    localparam int VFU_DATA_WIDTH = 64;
    localparam int VFU_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [63:0] data;
    } vmem_rsp_t;

    // Byte address to 64-bit word index; callers truncate to their depth.
    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return addr >> 3;
    endfunction

    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return (addr >> 3) < $unsigned(depth);
    endfunction

endpackage

// File: rtl/vfu_rsp_fifo.sv
// Synchronous response FIFO; valid is derived from registered pointers only.
module vfu_rsp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra MSB on each pointer distinguishes full from empty.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vfu_vmem_responder.sv
// Scratchpad memory endpoint for the vector core mem port: single-port store,
// credit-limited reads, in-order responses through vfu_rsp_fifo.
module vfu_vmem_responder
    import vfu_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = VFU_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = VFU_ADDR_WIDTH,
    parameter int DEPTH          = 512,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_port_req,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_port_addr_out,
    input  logic                      mem_port_valid_out,
    input  logic [DATA_WIDTH-1:0]     mem_port_out,
    output logic                      mem_port_req_rdy,
    output logic [DATA_WIDTH-1:0]     mem_port_in,
    output logic                      mem_port_valid_in,
    input  logic                      mem_port_ready_out,
    output logic                      err_oob,
    output logic                      err_misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_oob;
    logic                  r_inflight;
    logic [CW-1:0]         r_credits;
    logic                  r_err_oob;
    logic                  r_err_misalign;

    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_misalign;
    logic          w_accept;
    logic          w_pop;
    logic          w_fifo_valid;
    vmem_rsp_t     w_push_rsp;
    vmem_rsp_t     w_head_rsp;

    assign w_idx      = AW'(word_idx(mem_port_addr_out));
    assign w_in_range = addr_in_range(mem_port_addr_out, DEPTH);
    assign w_misalign = |mem_port_addr_out[2:0];

    // Handshakes: a read transfers when mem_port_req && mem_port_req_rdy, a
    // response when mem_port_valid_in && mem_port_ready_out; valid and head
    // data hold until that transfer. Writes have no backpressure and own the
    // single port, so they hold off read acceptance for that cycle.
    assign mem_port_req_rdy = (r_credits != '0) && !mem_port_valid_out;
    assign w_accept         = mem_port_req && mem_port_req_rdy;
    assign w_pop            = w_fifo_valid && mem_port_ready_out;

    assign w_push_rsp.data = r_rd_oob ? '0 : r_rd_data;

    always_ff @(posedge clk) begin
        if (mem_port_valid_out && w_in_range) begin
            r_mem[w_idx] <= mem_port_out;
        end else if (w_accept) begin
            r_rd_data <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight     <= 1'b0;
            r_rd_oob       <= 1'b0;
            r_credits      <= CW'(RSP_DEPTH);
            r_err_oob      <= 1'b0;
            r_err_misalign <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_rd_oob <= !w_in_range;
            end
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
            if ((mem_port_valid_out || w_accept) && !w_in_range) begin
                r_err_oob <= 1'b1;
            end
            if ((mem_port_valid_out || w_accept) && w_misalign) begin
                r_err_misalign <= 1'b1;
            end
        end
    end

    vfu_rsp_fifo #(
        .WIDTH ($bits(vmem_rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_inflight),
        .i_push_data (w_push_rsp),
        .i_pop       (w_pop),
        .o_valid     (w_fifo_valid),
        .o_data      (w_head_rsp)
    );

    assign mem_port_in       = w_head_rsp.data;
    assign mem_port_valid_in = w_fifo_valid;
    assign err_oob           = r_err_oob;
    assign err_misalign      = r_err_misalign;

endmodule

// File: tb/tb_vfu_vmem_responder.sv
// Directed bench for vfu_vmem_responder: linear steps with immediate assertions.
module tb_vfu_vmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic        valid_out;
    logic [63:0] wdata;
    logic        req_rdy;
    logic [63:0] rdata;
    logic        valid_in;
    logic        ready_out;
    logic        err_oob;
    logic        err_misalign;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    vfu_vmem_responder dut (
        .clk                (clk),
        .reset              (reset),
        .mem_port_req       (req),
        .mem_port_addr_out  (addr),
        .mem_port_valid_out (valid_out),
        .mem_port_out       (wdata),
        .mem_port_req_rdy   (req_rdy),
        .mem_port_in        (rdata),
        .mem_port_valid_in  (valid_in),
        .mem_port_ready_out (ready_out),
        .err_oob            (err_oob),
        .err_misalign       (err_misalign)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        req       = 1'b0;
        valid_out = 1'b1;
        addr      = a;
        wdata     = d;
        tick();
        valid_out = 1'b0;
    endtask

    function automatic logic [63:0] wpat(input int i);
        return 64'h0123_4567_0000_0000 + 64'(i) * 64'h1111;
    endfunction

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        addr      = '0;
        valid_out = 1'b0;
        wdata     = '0;
        ready_out = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // 1: idle after reset
        for (int c = 0; c < 10; c++) begin
            check("idle_valid_in", 64'(valid_in), 64'd0);
            check("idle_rdata", rdata, 64'd0);
            check("idle_err_oob", 64'(err_oob), 64'd0);
            check("idle_err_mis", 64'(err_misalign), 64'd0);
            check("idle_req_rdy", 64'(req_rdy), 64'd1);
            tick();
        end

        // 2: write then read-after-write, latency 2
        wr(32'h40, 64'h1122_3344_5566_7788);
        req       = 1'b1;
        addr      = 32'h40;
        ready_out = 1'b1;
        #1 check("raw_req_rdy", 64'(req_rdy), 64'd1);
        tick();
        req = 1'b0;
        check("raw_lat1_valid", 64'(valid_in), 64'd0);
        tick();
        check("raw_lat2_valid", 64'(valid_in), 64'd1);
        check("raw_lat2_data", rdata, 64'h1122_3344_5566_7788);
        tick();
        check("raw_one_cycle", 64'(valid_in), 64'd0);

        // preload words 0..8
        for (int i = 0; i < 9; i++) wr(32'(i * 8), wpat(i));

        // 3: credit limit with stalled consumer
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req  = 1'b1;
            addr = 32'(i * 8);
            #1 check("cred_req_rdy", 64'(req_rdy), 64'd1);
            exp_q.push_back(wpat(i));
            tick();
        end
        addr = 32'h20;
        for (int c = 0; c < 3; c++) begin
            #1 check("cred_exhausted", 64'(req_rdy), 64'd0);
            tick();
        end
        check("full_head_valid", 64'(valid_in), 64'd1);
        check("full_head_data", rdata, wpat(0));
        req       = 1'b0;
        ready_out = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 64'(valid_in), 64'd1);
            check("drain_order", rdata, exp_q.pop_front());
            tick();
        end
        check("drain_empty", 64'(valid_in), 64'd0);
        for (int i = 4; i < 6; i++) begin
            req  = 1'b1;
            addr = 32'(i * 8);
            #1 check("rest_req_rdy", 64'(req_rdy), 64'd1);
            tick();
        end
        req = 1'b0;
        check("rest_rsp4", rdata, wpat(4));
        check("rest_rsp4_v", 64'(valid_in), 64'd1);
        tick();
        check("rest_rsp5", rdata, wpat(5));
        check("rest_rsp5_v", 64'(valid_in), 64'd1);
        tick();
        check("rest_empty", 64'(valid_in), 64'd0);

        // 4: write and read in the same cycle
        valid_out = 1'b1;
        req       = 1'b1;
        addr      = 32'h50;
        wdata     = 64'hCAFE_F00D_1234_5678;
        #1 check("coll_req_rdy", 64'(req_rdy), 64'd0);
        tick();
        valid_out = 1'b0;
        #1 check("coll_retry_rdy", 64'(req_rdy), 64'd1);
        tick();
        req = 1'b0;
        check("coll_lat1", 64'(valid_in), 64'd0);
        tick();
        check("coll_valid", 64'(valid_in), 64'd1);
        check("coll_data", rdata, 64'hCAFE_F00D_1234_5678);
        tick();

        // 5: out-of-range and misaligned accesses
        check("oob_clear", 64'(err_oob), 64'd0);
        req  = 1'b1;
        addr = 32'h1000;
        tick();
        req = 1'b0;
        check("oob_set_rd", 64'(err_oob), 64'd1);
        tick();
        check("oob_rd_valid", 64'(valid_in), 64'd1);
        check("oob_rd_zero", rdata, 64'd0);
        tick();
        wr(32'h1008, 64'hDEAD_BEEF_DEAD_BEEF);
        check("oob_sticky", 64'(err_oob), 64'd1);
        req  = 1'b1;
        addr = 32'h8;
        tick();
        req = 1'b0;
        tick();
        check("oob_no_alias", rdata, wpat(1));
        tick();
        check("mis_clear", 64'(err_misalign), 64'd0);
        req  = 1'b1;
        addr = 32'h43;
        tick();
        req = 1'b0;
        check("mis_set", 64'(err_misalign), 64'd1);
        tick();
        check("mis_data", rdata, wpat(8));
        tick();

        // 6: reset with two queued and one in flight
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req  = 1'b1;
            addr = 32'(i * 8);
            tick();
        end
        req   = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_valid", 64'(valid_in), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_err_oob", 64'(err_oob), 64'd0);
        check("rst_err_mis", 64'(err_misalign), 64'd0);
        ready_out = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rst_no_stale", 64'(valid_in), 64'd0);
        end
        ready_out = 1'b0;
        for (int i = 1; i < 5; i++) begin
            req  = 1'b1;
            addr = 32'(i * 8);
            #1 check("rst_credit", 64'(req_rdy), 64'd1);
            exp_q.push_back(wpat(i));
            tick();
        end
        #1 check("rst_credit_end", 64'(req_rdy), 64'd0);
        req = 1'b0;
        tick();
        ready_out = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("rst_mem_valid", 64'(valid_in), 64'd1);
            check("rst_mem_kept", rdata, exp_q.pop_front());
            tick();
        end
        check("rst_final_empty", 64'(valid_in), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
